// File: rtl/fc_quant_wb_ctrl_pkg.sv
// Shared definitions for the FC output phase: FSM encoding, requantization
// constants, saturation bounds and the byte-lane helpers.
package fc_quant_wb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Layer rule selector values carried on fc_state.
    localparam logic FC1_STATE = 1'b0;
    localparam logic FC2_STATE = 1'b1;

    // Round-half-up offsets and arithmetic shift amounts.
    localparam int FC1_ROUND = 32;
    localparam int FC1_SHIFT = 6;
    localparam int FC2_ROUND = 16;
    localparam int FC2_SHIFT = 5;

    // Saturation bounds (FC1 output is non-negative, FC2 is full int8).
    localparam int SAT_MAX     = 127;
    localparam int FC1_SAT_MIN = 0;
    localparam int FC2_SAT_MIN = -128;

    // Requantize one 32-bit accumulator to int8. The rounding add is done
    // in 33 bits so that 0x7FFFFFFF + round stays positive.
    function automatic logic [7:0] requant(input logic rule, input logic [31:0] acc);
        logic signed [32:0] wide;
        logic signed [32:0] shifted;
        logic signed [32:0] lo;
        logic signed [32:0] hi;
        wide = $signed({acc[31], acc});
        hi   = 33'(SAT_MAX);
        if (rule == FC2_STATE) begin
            shifted = (wide + 33'(FC2_ROUND)) >>> FC2_SHIFT;
            lo      = 33'(FC2_SAT_MIN);
        end else begin
            shifted = (wide + 33'(FC1_ROUND)) >>> FC1_SHIFT;
            lo      = 33'(FC1_SAT_MIN);
        end
        if (shifted > hi) begin
            shifted = hi;
        end else if (shifted < lo) begin
            shifted = lo;
        end
        return shifted[7:0];
    endfunction

    // Byte mask covering lanes 0..last_lane.
    function automatic logic [3:0] fill_mask(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/fc_byte_packer.sv
// Packs int8 results into 32-bit words (lane 0 first) and drives the
// activation SRAM write port with an auto-incrementing word address.
module fc_byte_packer
    import fc_quant_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              empty,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bytemask
);

    logic [1:0]        lane_q,  lane_d;
    logic [31:0]       pack_q,  pack_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q,  mask_d;
    logic [31:0]       merged;

    assign empty         = (lane_q == 2'd0);
    assign sram_wen      = wen_q;
    assign sram_waddr    = waddr_q;
    assign sram_wdata    = wdata_q;
    assign sram_bytemask = mask_q;

    // Merge the incoming byte into its lane; emit a word when lane 3 fills
    // or the layer ends, otherwise advance the lane.
    always_comb begin
        lane_d  = lane_q;
        pack_d  = pack_q;
        addr_d  = addr_q;
        wen_d   = 1'b1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        merged  = pack_q;
        merged[{lane_q, 3'b000} +: 8] = in_byte;
        if (load) begin
            lane_d = 2'd0;
            pack_d = '0;
            addr_d = base_addr;
        end else if (in_valid) begin
            if (lane_q == 2'd3 || in_last) begin
                // Unfilled upper lanes of a partial word are still zero.
                wen_d   = 1'b0;
                waddr_d = addr_q;
                wdata_d = merged;
                mask_d  = fill_mask(lane_q);
                addr_d  = addr_q + ADDR_W'(1);
                lane_d  = 2'd0;
                pack_d  = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                pack_d = merged;
            end
        end
    end

    // Packer and write-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            lane_q  <= 2'd0;
            pack_q  <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: rtl/fc_quant_wb_ctrl.sv
// FC layer output-phase controller: accepts accumulator results, requantizes
// them to int8 in one registered stage and hands them to the byte packer,
// which writes packed words to the activation SRAM.
module fc_quant_wb_ctrl
    import fc_quant_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              start,
    input  logic              fc_state,
    input  logic [LEN_W-1:0]  out_len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              acc_valid,
    input  logic [31:0]       acc_data,
    output logic              acc_ready,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bytemask,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic             fc_q,    fc_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic             q_valid_q, q_valid_d;
    logic             q_last_q,  q_last_d;
    logic [7:0]       q_byte_q,  q_byte_d;
    logic             done_q,    done_d;
    logic             xfer;
    logic             load;
    logic             pack_empty;

    assign acc_ready = (state_q == ST_RUN) && (cnt_q < len_q);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign xfer      = acc_valid && acc_ready;
    assign load      = (state_q == ST_IDLE) && start;
    assign cnt_inc   = cnt_q + LEN_W'(1);

    // Next-state logic: latch the job on start, count transfers, drain, finish.
    // NOTE: every signal gets its default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fc_d    = fc_state;
                    len_d   = out_len;
                    cnt_d   = '0;
                    state_d = (out_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // The last result leaves the quantize stage this edge, so the
                // final word is on the SRAM port while in DONE.
                if ((q_valid_q && q_last_q) || (!q_valid_q && pack_empty)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Quantize stage input: capture each transferred result and mark the last.
    always_comb begin
        q_valid_d = xfer;
        q_last_d  = xfer && (cnt_inc == len_q);
        q_byte_d  = xfer ? requant(fc_q, acc_data) : q_byte_q;
    end

    // Control and quantize-stage registers with synchronous reset.
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q   <= ST_IDLE;
            fc_q      <= FC1_STATE;
            len_q     <= '0;
            cnt_q     <= '0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
            q_byte_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fc_q      <= fc_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
            q_byte_q  <= q_byte_d;
            done_q    <= done_d;
        end
    end

    fc_byte_packer #(
        .ADDR_W(ADDR_W)
    ) u_packer (
        .clk           (clk),
        .srstn         (srstn),
        .load          (load),
        .base_addr     (base_addr),
        .in_valid      (q_valid_q),
        .in_byte       (q_byte_q),
        .in_last       (q_last_q),
        .empty         (pack_empty),
        .sram_wen      (sram_wen),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .sram_bytemask (sram_bytemask)
    );

endmodule

// File: tb/tb_fc_quant_wb_ctrl.sv
// Scoreboard bench for fc_quant_wb_ctrl: expected SRAM writes are queued as
// results are handed over and compared as the write port reports them.
module tb_fc_quant_wb_ctrl;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          cyc;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        start = 1'b0;
    logic        fc_state = 1'b0;
    logic [9:0]  out_len = '0;
    logic [9:0]  base_addr = '0;
    logic        acc_valid = 1'b0;
    logic [31:0] acc_data = '0;
    logic        acc_ready;
    logic        sram_wen;
    logic [9:0]  sram_waddr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_bytemask;
    logic        busy;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_done = 0;
    exp_wr_t     sb[$];
    exp_wr_t     got;
    logic [31:0] stim[$];

    fc_quant_wb_ctrl #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk           (clk),
        .srstn         (srstn),
        .start         (start),
        .fc_state      (fc_state),
        .out_len       (out_len),
        .base_addr     (base_addr),
        .acc_valid     (acc_valid),
        .acc_data      (acc_data),
        .acc_ready     (acc_ready),
        .sram_wen      (sram_wen),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .sram_bytemask (sram_bytemask),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference requantizer using 64-bit arithmetic.
    function automatic logic [7:0] ref_quant(input logic fc, input logic [31:0] x);
        longint v;
        longint lo;
        v = longint'($signed(x));
        if (fc) begin
            v  = (v + 16) >>> 5;
            lo = -128;
        end else begin
            v  = (v + 32) >>> 6;
            lo = 0;
        end
        if (v > 127) v = 127;
        if (v < lo) v = lo;
        return v[7:0];
    endfunction

    // Write-port monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (sram_wen !== 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h mask=%b, expected no write",
                         sram_waddr, sram_wdata, sram_bytemask);
            end else begin
                got = sb.pop_front();
                if ({sram_waddr, sram_wdata, sram_bytemask} !== {got.addr, got.data, got.mask}) begin
                    errors++;
                    $display("FAIL write_word: got addr=%h data=%h mask=%b, expected addr=%h data=%h mask=%b",
                             sram_waddr, sram_wdata, sram_bytemask, got.addr, got.data, got.mask);
                end
                checks++;
                if (cyc != got.cyc) begin
                    errors++;
                    $display("FAIL write_cycle: got cycle %0d, expected cycle %0d", cyc, got.cyc);
                end
            end
        end
    end

    task automatic pulse_start(input logic fc, input logic [9:0] len, input logic [9:0] base,
                               output int start_cyc);
        @(negedge clk);
        start = 1'b1; fc_state = fc; out_len = len; base_addr = base;
        start_cyc = cyc;
        @(negedge clk);
        // Disturb the job inputs while busy; the latched copies must hold.
        start = 1'b0; fc_state = ~fc; out_len = ~len; base_addr = ~base;
    endtask

    // Start a layer and stream stim[0..len-1]; queue each word when its last
    // byte is handed over.
    task automatic run_layer(input logic fc, input int len, input logic [9:0] base,
                             input int gap_at, input int gap_len, input bit poke_start);
        logic [31:0] word;
        exp_wr_t     we;
        int lane, i, wi, gap_left, guard, start_cyc;
        pulse_start(fc, len[9:0], base, start_cyc);
        exp_done = start_cyc + 2;
        word = '0; lane = 0; i = 0; wi = 0; gap_left = gap_len; guard = 0;
        if (len > 0) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_run: busy=%b expected 1", busy);
            end
        end
        while (i < len && guard < 500) begin
            start = 1'b0;
            if (poke_start && i == 2) begin
                start = 1'b1; fc_state = ~fc; out_len = 10'd1; base_addr = ~base;
            end
            if (i == gap_at && gap_left > 0) begin
                acc_valid = 1'b0;
                gap_left--;
            end else begin
                acc_valid = 1'b1;
                acc_data  = stim[i];
                if (acc_ready) begin
                    word = word | (32'(ref_quant(fc, stim[i])) << (8 * lane));
                    lane++;
                    i++;
                    if (lane == 4 || i == len) begin
                        we.addr = base + 10'(wi);
                        we.data = word;
                        we.mask = 4'((1 << lane) - 1);
                        we.cyc  = cyc + 2;
                        sb.push_back(we);
                        exp_done = we.cyc + 1;
                        wi++; lane = 0; word = '0;
                    end
                end
            end
            guard++;
            @(negedge clk);
        end
        acc_valid = 1'b0;
        start = 1'b0;
        if (guard >= 500) begin
            checks++; errors++;
            $display("FAIL stream_timeout: sent %0d of %0d results", i, len);
        end
        if (len > 0) begin
            checks++;
            if (acc_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_last: acc_ready=%b expected 0", acc_ready);
            end
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b expected 1 within 60 cycles", done);
        end else begin
            checks++;
            if (cyc != exp_done) begin
                errors++;
                $display("FAIL done_cycle: got cycle %0d, expected cycle %0d", cyc, exp_done);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({acc_ready, sram_wen, sram_waddr, sram_wdata, sram_bytemask, busy, done} !==
            {1'b0, 1'b1, 10'd0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: ready=%b wen=%b addr=%h data=%h mask=%b busy=%b done=%b, expected 0 1 000 00000000 0000 0 0",
                     tag, acc_ready, sram_wen, sram_waddr, sram_wdata, sram_bytemask, busy, done);
        end
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        srstn = 1'b1;
    endtask

    task automatic test_fc1_full_word();
        stim = '{32'd100, 32'd8191, 32'(-50), 32'd64};
        run_layer(1'b0, 4, 10'h010, -1, 0, 1'b0);
        wait_done();
    endtask

    task automatic test_fc2_partial();
        stim = '{32'(-5000), 32'd47};
        run_layer(1'b1, 2, 10'h020, -1, 0, 1'b0);
        wait_done();
    endtask

    task automatic test_gaps();
        stim = '{32'd500, 32'd1000, 32'd2000, 32'(-300), 32'd4000, 32'd7000};
        run_layer(1'b0, 6, 10'h040, 2, 3, 1'b0);
        wait_done();
    endtask

    task automatic test_zero_len_and_busy_start();
        run_layer(1'b0, 0, 10'h100, -1, 0, 1'b0);
        wait_done();
        stim = '{32'd320, 32'(-320), 32'd3200, 32'(-3200)};
        run_layer(1'b1, 4, 10'h123, -1, 0, 1'b1);
        wait_done();
    endtask

    task automatic test_addr_wrap();
        stim = '{32'd1, 32'd31, 32'd32, 32'd100, 32'(-100), 32'd2000, 32'(-2000), 32'd4063};
        run_layer(1'b1, 8, 10'h3FF, -1, 0, 1'b0);
        wait_done();
    endtask

    task automatic test_saturation_edges();
        stim = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd31, 32'd95, 32'd96, 32'd8159, 32'd8160,
                 32'(-16), 32'(-17), 32'd4064, 32'(-4112), 32'(-4113)};
        for (int r = 0; r < 2; r++) begin
            run_layer(r[0], 12, 10'h080, -1, 0, 1'b0);
            wait_done();
        end
    endtask

    task automatic test_mid_reset();
        int start_cyc;
        int i = 0;
        int guard = 0;
        stim = '{32'd10, 32'd20, 32'd30, 32'd40};
        pulse_start(1'b0, 10'd4, 10'h055, start_cyc);
        while (i < 3 && guard < 50) begin
            acc_valid = 1'b1;
            acc_data  = stim[i];
            if (acc_ready) i++;
            guard++;
            @(negedge clk);
        end
        acc_valid = 1'b0;
        // The third result now sits in the quantize stage.
        srstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort_values");
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_done: done=%b expected 0", done);
            end
        end
        srstn = 1'b1;
        stim = '{32'd700, 32'(-700), 32'd70};
        run_layer(1'b1, 3, 10'h200, -1, 0, 1'b0);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int len;
        logic fc;
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(1, 13));
            fc  = 1'($urandom_range(0, 1));
            stim.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) stim.push_back($urandom);
                else stim.push_back(32'($urandom_range(0, 16000)) - 32'd8000);
            end
            run_layer(fc, len, 10'($urandom), -1, 0, 1'b0);
            wait_done();
        end
    endtask

    initial begin
        test_reset();
        test_fc1_full_word();
        test_fc2_partial();
        test_gaps();
        test_zero_len_and_busy_start();
        test_addr_wrap();
        test_saturation_edges();
        test_mid_reset();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fc_quant_wb_ctrl.md
Name: fc_quant_wb_ctrl

Overview:
Sequences one fully-connected layer's output phase. Accepts the stream of 32-bit accumulator results from the FC MAC array and requantizes each result to int8 using the per-layer rounding/shift/saturation rule. Packs four int8 results into each 32-bit word and writes the words to the activation SRAM from a base address, then pulses done. Sits between the FC MAC array and the activation SRAM write port, under the top-level layer scheduler.

Parameters:
ADDR_W, 10, SRAM word-address width
LEN_W, 10, width of the output-count field (max 2^LEN_W-1 outputs)

Ports:
clk  in  1  clock
srstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begin layer output phase (honoured in IDLE only)
fc_state  in  1  0 = FC1 rule, 1 = FC2 rule; latched on start
out_len  in  LEN_W  number of results to process, latched on start; 0 is legal
base_addr  in  ADDR_W  first SRAM word address, latched on start
acc_valid  in  1  accumulator result valid
acc_data  in  32  signed accumulator result
acc_ready  out  1  controller accepts acc_data this cycle
sram_wen  out  1  active-low write enable
sram_waddr  out  ADDR_W  write word address
sram_wdata  out  32  packed int8 results, element k of a word in bits [8k+7:8k]
sram_bytemask  out  4  1 = byte lane written
busy  out  1  high in RUN/FLUSH/DONE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock is clk. Reset is synchronous, active-low on srstn. Reset is the only reset.
- Reset values: state=IDLE, acc_ready=0, sram_wen=1, sram_waddr=0, sram_wdata=0, sram_bytemask=0, busy=0, done=0. All counters and the pack register are 0.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: when start=1, latch fc_state, out_len and base_addr. Clear the accepted count, lane index and pack register. If out_len=0, go to DONE; otherwise go to RUN. All other inputs are ignored in IDLE.
- RUN: acc_ready=1 while the accepted count is below out_len. A transfer happens when acc_valid&acc_ready. After the transfer that makes the count equal out_len, acc_ready drops in the next cycle and the FSM goes to FLUSH.
- FLUSH: wait until the quantize stage is empty and the final word has been written, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start while busy is ignored. fc_state, out_len and base_addr changes while busy are ignored.
- Quantize stage: one registered stage, with the rule selected by the latched fc_state.
  - FC1: r = (x + 32) >>> 6 (arithmetic shift); saturate to [0, 127].
  - FC2: r = (x + 16) >>> 5; saturate to [-128, 127].
  - The rounding add is done in 33 bits so 0x7FFFFFFF does not wrap.
  - The output byte is the saturated shifted value.
- Packing: quantized bytes fill lanes 0..3 in order.
  - Write on lane 3 fill, or on the last element of the layer.
  - A partial final word has its unfilled lanes set to 0 and its bytemask covering only the filled lanes.
  - The word address starts at base_addr and increments by 1 per write, wrapping modulo 2^ADDR_W.
- Latency: a result transferred in cycle t is quantized in register t+1. Its word is presented on the registered SRAM outputs at t+2 when that word completes. sram_wen is low for exactly one cycle per word.
- Gaps in acc_valid stall packing only. No word is written until it is full or it is the last word.
- The SRAM always accepts writes, so there is no write backpressure.
- done asserts the cycle after the last write is presented. For out_len=0, done asserts 2 cycles after start and no write occurs.
- srstn low mid-operation: abort immediately to reset values next cycle. No partial word is written and done is not asserted.

Decomposition:
- Shared FC package: FSM state encoding; constants FC1_STATE=0, FC2_STATE=1; FC1_ROUND=32, FC1_SHIFT=6, FC2_ROUND=16, FC2_SHIFT=5; saturation bounds.
- One natural sub-module: fc_byte_packer. It holds the lane index, the pack register, bytemask generation and the address counter.
- The FSM and quantize stage stay in the top of fc_quant_wb_ctrl.

Test Plan:
- FC1, out_len=4, base=0x010, data {100, 8191, -50, 64} -> one write: addr 0x010, wdata 0x01_00_7F_02, mask 1111; done 1 cycle later.
- FC2, out_len=2, data {-5000, 47} -> one write: wdata 0x0000_0180, mask 0011; -5000 saturates to 0x80.
- FC1, out_len=6, with acc_valid low for 3 cycles between the 2nd and 3rd results -> writes at addr base (mask 1111) and base+1 (mask 0011); acc_ready low after the 6th transfer.
- out_len=0 start -> no sram_wen, done 2 cycles after start; a start pulse during busy of another run is ignored (address and count unchanged).
- base=0x3FF, out_len=8 -> writes at 0x3FF then 0x000.
- srstn low while the 3rd of 4 results is in flight -> all outputs at reset values next cycle, no write or done; a following start runs cleanly.
